regfile_multiport_bypass: RTL and testbench
===========================================

Name: regfile_multiport_bypass

Overview:
- Parametrised integer register file: WIDTH-bit entries, NUM_REGS entries, NUM_RD_PORTS independent read ports, one synchronous write port.
- Next generation of the vectored 32:1 read-select mux. Adds storage, write-to-read bypass, a hardwired zero register, out-of-range handling and an optional registered read stage with valid handshake.
- Sits in the Decode stage of the pipelined CPU. Writeback drives the write port; operand fetch drives the read ports.

Parameters:
- WIDTH, 64: data bits per register.
- NUM_REGS, 32: number of architectural registers; any value 2..64.
- NUM_RD_PORTS, 2: number of read ports, 1..4.
- ZERO_REG, 31: index that always reads 0 and ignores writes.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the old value.
- READ_LATENCY, 0: 0 = combinational read; 1 = registered read.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable.
- wr_addr  input  AW  write index, where AW = clog2(NUM_REGS).
- wr_data  input  WIDTH  write data.
- rd_en  input  NUM_RD_PORTS  per-port read request.
- rd_addr  input  [NUM_RD_PORTS][AW]  per-port read index.
- rd_data  output  [NUM_RD_PORTS][WIDTH]  per-port read data.
- rd_valid  output  NUM_RD_PORTS  per-port data-valid.

Behaviour:
- Reset (reset_n low, asynchronous): all registers cleared to 0; registered rd_data cleared to 0; rd_valid cleared to 0. A write presented in a cycle where reset is asserted is dropped. State is held at 0 until the first rising clk edge after reset_n deasserts.
- Write: on the rising clk edge with wr_en=1, regs[wr_addr] <= wr_data. The write is suppressed when wr_addr == ZERO_REG or wr_addr >= NUM_REGS.
- Per-port read value, per port p, in priority order:
  - 0 when rd_addr[p] == ZERO_REG or rd_addr[p] >= NUM_REGS;
  - otherwise wr_data when BYPASS=1 and wr_en=1 and wr_addr == rd_addr[p];
  - otherwise regs[rd_addr[p]].
- The ZERO_REG rule takes priority over bypass: a write aimed at ZERO_REG is never forwarded.
- READ_LATENCY=0:
  - rd_data[p] = read value, combinational.
  - rd_valid[p] = rd_en[p], combinational.
  - rd_data is driven regardless of rd_en.
- READ_LATENCY=1:
  - On a rising edge with rd_en[p]=1: rd_data[p] <= read value evaluated in that cycle, so the bypass applies to the concurrent write; rd_valid[p] <= 1.
  - With rd_en[p]=0: rd_data[p] holds its previous value; rd_valid[p] <= 0.
  - Latency is exactly 1 cycle. Back-to-back reads are supported every cycle.
- Multiple ports may read the same index in the same cycle; every port returns an identical value.
- There are no stalls and no backpressure. The block is always ready.
- Widths: no truncation or extension; data passes through bit-exact.

Decomposition:
- Package regfile_pkg holds:
  - the function addr_w(n) = clog2(n), with a minimum of 1;
  - localparam defaults DEF_WIDTH=64, DEF_NUM_REGS=32, DEF_ZERO_REG=31;
  - typedef reg_idx_t for the default address width.
- One sub-module: mux_nx1_w, a parametrised N:1 WIDTH-bit select mux.
  - Instantiated once per read port over the register array.
  - Bypass, zero-register and range logic are wrapped around it in the parent.
- Storage is a flat flop array in the parent. No memory macro.

Test Plan:
1. Reset with all ports reading index 5 → rd_data=0 on all ports, rd_valid=0. Write 0xDEAD_BEEF to X5, then read on port 0 at READ_LATENCY=0 → 0x00000000DEADBEEF in the next cycle.
2. Zero register: write 0x1234 to X31, then read X31 on both ports → 0. The same-cycle bypass of that write also returns 0 with BYPASS=1.
3. Bypass: in one cycle write 0xAAAA to X7 while port 1 reads X7. BYPASS=1 → port 1 returns 0xAAAA that cycle. BYPASS=0 → port 1 returns the prior value 0x0, then 0xAAAA in the next cycle.
4. READ_LATENCY=1: set rd_en=2'b01 with rd_addr[0]=3 (X3=0x55) for one cycle, then rd_en=0. Required: rd_valid[0]=1 with rd_data[0]=0x55 exactly one cycle later; rd_valid[0]=0 after that, with data held at 0x55. rd_valid[1] stays 0 throughout.
5. Out of range with NUM_REGS=20: write to index 25 is ignored; reading index 25 returns 0; X0–X19 are unchanged.
6. Reset mid-operation: assert reset_n low asynchronously between edges while wr_en=1 to X9. Required: all registers 0 and rd_valid=0 immediately; after release, X9 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: address-width helper,
// default geometry and the default register index type.
package regfile_pkg;

  // Index width for an n-entry array; never narrower than one bit.
  function automatic int addr_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ZERO_REG = 31;

  typedef logic [addr_w(DEF_NUM_REGS)-1:0] reg_idx_t;

endpackage : regfile_pkg

// File: rtl/mux_nx1_w.sv
// Parametrised N:1 select mux of WIDTH-bit words. A select value with no
// matching input yields zero.
module mux_nx1_w
  import regfile_pkg::*;
#(
  parameter  int N     = 2,
  parameter  int WIDTH = 1,
  localparam int SW    = addr_w(N)
) (
  input  logic [WIDTH-1:0] din [N],
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] dout
);

  // Pick the input whose index equals sel.
  always_comb begin
    // NOTE: default assignment first so every path drives dout and no latch is inferred.
    dout = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) dout = din[i];
    end
  end

endmodule : mux_nx1_w

// File: rtl/regfile_multiport_bypass.sv
// Integer register file for the Decode stage: NUM_RD_PORTS read ports, one
// write port from Writeback, optional write-to-read bypass, a hardwired zero
// register, out-of-range suppression and an optional registered read stage.
module regfile_multiport_bypass
  import regfile_pkg::*;
#(
  parameter  int WIDTH        = DEF_WIDTH,
  parameter  int NUM_REGS     = DEF_NUM_REGS,
  parameter  int NUM_RD_PORTS = 2,
  parameter  int ZERO_REG     = DEF_ZERO_REG,
  parameter  int BYPASS       = 1,
  parameter  int READ_LATENCY = 0,
  localparam int AW           = addr_w(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 wr_en,
  input  logic [AW-1:0]                        wr_addr,
  input  logic [WIDTH-1:0]                     wr_data,
  input  logic [NUM_RD_PORTS-1:0]              rd_en,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]              rd_valid
);

  logic [WIDTH-1:0]                   regs    [NUM_REGS];
  logic [WIDTH-1:0]                   mux_out [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0][WIDTH-1:0] rd_val;
  logic                               wr_ok;

  // A write lands only when it targets a real, non-zero register.
  assign wr_ok = wr_en
              && (int'(wr_addr) != ZERO_REG)
              && (int'(wr_addr) <  NUM_REGS);

  // Architectural storage: cleared on reset, one entry updated per edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the whole array is reset because software relies on every register reading 0 after reset; this keeps it a flop array, not a RAM.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: non-blocking so every flop samples pre-edge values and simulation matches the synthesised registers.
        if (wr_ok && (int'(wr_addr) == i)) regs[i] <= wr_data;
      end
    end
  end

  // One select mux per read port over the storage array.
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port_mux
    mux_nx1_w #(
      .N     (NUM_REGS),
      .WIDTH (WIDTH)
    ) u_mux (
      .din  (regs),
      .sel  (rd_addr[p]),
      .dout (mux_out[p])
    );
  end

  // Per-port read value: zero/out-of-range first, then bypass, then storage.
  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if ((int'(rd_addr[p]) == ZERO_REG) || (int'(rd_addr[p]) >= NUM_REGS)) begin
        rd_val[p] = '0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr[p])) begin
        rd_val[p] = wr_data;
      end else begin
        rd_val[p] = mux_out[p];
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_read
    assign rd_data  = rd_val;
    assign rd_valid = rd_en;
  end else begin : g_reg_read
    // Registered read stage: capture on request, hold data otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_data  <= '0;
        rd_valid <= '0;
      end else begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
          rd_valid[p] <= rd_en[p];
          if (rd_en[p]) rd_data[p] <= rd_val[p];
        end
      end
    end
  end

endmodule : regfile_multiport_bypass

// File: tb/tb_regfile_multiport_bypass.sv
// Self-checking bench: four configurations share one stimulus stream
// (0: bypass/comb, 1: no bypass/comb, 2: bypass/registered, 3: 20 regs/comb).
module tb_regfile_multiport_bypass;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [63:0]     wr_data;
  logic [1:0]      rd_en;
  logic [1:0][4:0] rd_addr;

  logic [1:0][63:0] rdat0, rdat1, rdat2, rdat3;
  logic [1:0]       rval0, rval1, rval2, rval3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per configuration.
  logic [63:0] mreg [4][32];
  logic [63:0] exp_q_data  [2];
  logic        exp_q_valid [2];

  always #5 clk = ~clk;

  regfile_multiport_bypass #(.BYPASS(1), .READ_LATENCY(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat0), .rd_valid(rval0));
  regfile_multiport_bypass #(.BYPASS(0), .READ_LATENCY(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat1), .rd_valid(rval1));
  regfile_multiport_bypass #(.BYPASS(1), .READ_LATENCY(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat2), .rd_valid(rval2));
  regfile_multiport_bypass #(.NUM_REGS(20), .BYPASS(1), .READ_LATENCY(0)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat3), .rd_valid(rval3));

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] e0_0;   // config 0, port 0
    logic [63:0] e0_1;   // config 0, port 1
    logic [63:0] e1_1;   // config 1, port 1
    logic [63:0] e3_1;   // config 3, port 1
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nregs(input int inst);
    return (inst == 3) ? 20 : 32;
  endfunction

  // Architectural read rule using current bench inputs.
  function automatic logic [63:0] mread(input int inst, input int a);
    if (a == 31 || a >= nregs(inst)) return 64'h0;
    if (inst != 1 && wr_en && int'(wr_addr) == a) return wr_data;
    return mreg[inst][a];
  endfunction

  function automatic logic [63:0] got_data(input int inst, input int p);
    case (inst)
      0:       return rdat0[p];
      1:       return rdat1[p];
      2:       return rdat2[p];
      default: return rdat3[p];
    endcase
  endfunction

  function automatic logic got_valid(input int inst, input int p);
    case (inst)
      0:       return rval0[p];
      1:       return rval1[p];
      2:       return rval2[p];
      default: return rval3[p];
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 32; a++) mreg[i][a] = 64'h0;
    for (int p = 0; p < 2; p++) begin
      exp_q_data[p]  = 64'h0;
      exp_q_valid[p] = 1'b0;
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    rd_en      = re;
    rd_addr[0] = ra0;
    rd_addr[1] = ra1;
  endtask

  // Compare every configuration against the reference for the present inputs.
  task automatic check_model();
    for (int inst = 0; inst < 4; inst++) begin
      for (int p = 0; p < 2; p++) begin
        if (inst == 2) begin
          check($sformatf("cfg2_data%0d", p), got_data(2, p), exp_q_data[p]);
          check($sformatf("cfg2_valid%0d", p), 64'(got_valid(2, p)), 64'(exp_q_valid[p]));
        end else begin
          check($sformatf("cfg%0d_data%0d_a%0d", inst, p, rd_addr[p]),
                got_data(inst, p), mread(inst, int'(rd_addr[p])));
          check($sformatf("cfg%0d_valid%0d", inst, p), 64'(got_valid(inst, p)), 64'(rd_en[p]));
        end
      end
    end
  endtask

  // Advance one clock, updating the reference with this cycle's effects.
  task automatic tick();
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) exp_q_data[p] = mread(2, int'(rd_addr[p]));
      exp_q_valid[p] = rd_en[p];
    end
    if (wr_en && wr_addr != 5'd31)
      for (int inst = 0; inst < 4; inst++)
        if (int'(wr_addr) < nregs(inst)) mreg[inst][wr_addr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_clear();
    reset_n = 1'b0;
    set_in(1'b0, 5'd0, 64'h0, 2'b00, 5'd5, 5'd5);

    tbl[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF, 2'b11, 5'd0,  5'd0,  64'h0, 64'h0, 64'h0, 64'h0};
    tbl[1] = '{1'b0, 5'd0,  64'h0,         2'b11, 5'd5,  5'd5,  64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF};
    tbl[2] = '{1'b1, 5'd31, 64'h1234,      2'b11, 5'd31, 5'd31, 64'h0, 64'h0, 64'h0, 64'h0};
    tbl[3] = '{1'b0, 5'd0,  64'h0,         2'b10, 5'd31, 5'd31, 64'h0, 64'h0, 64'h0, 64'h0};
    tbl[4] = '{1'b1, 5'd7,  64'hAAAA,      2'b11, 5'd5,  5'd7,  64'hDEAD_BEEF, 64'hAAAA, 64'h0, 64'hAAAA};
    tbl[5] = '{1'b0, 5'd0,  64'h0,         2'b11, 5'd7,  5'd7,  64'hAAAA, 64'hAAAA, 64'hAAAA, 64'hAAAA};
    tbl[6] = '{1'b1, 5'd3,  64'h55,        2'b11, 5'd3,  5'd31, 64'h55, 64'h0, 64'h0, 64'h0};
    tbl[7] = '{1'b1, 5'd25, 64'hBAD,       2'b11, 5'd25, 5'd3,  64'hBAD, 64'h55, 64'h55, 64'h55};
    tbl[8] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 5'd0, 5'd25,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hBAD, 64'hBAD, 64'h0};
    tbl[9] = '{1'b0, 5'd0,  64'h0,         2'b11, 5'd0,  5'd19, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0};

    // Reset state with all ports addressing X5.
    #2;
    check("rst_cfg0_data", rdat0[0] | rdat0[1], 64'h0);
    check("rst_cfg2_data", rdat2[0] | rdat2[1], 64'h0);
    check("rst_cfg2_valid", 64'(rval2), 64'h0);
    check("rst_cfg0_valid", 64'(rval0), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra0, tbl[i].ra1);
      @(negedge clk);
      check_model();
      check($sformatf("vec%0d_cfg0_p0", i), rdat0[0], tbl[i].e0_0);
      check($sformatf("vec%0d_cfg0_p1", i), rdat0[1], tbl[i].e0_1);
      check($sformatf("vec%0d_cfg1_p1", i), rdat1[1], tbl[i].e1_1);
      check($sformatf("vec%0d_cfg3_p1", i), rdat3[1], tbl[i].e3_1);
      tick();
    end

    // Registered read: one request on port 0 for X3.
    set_in(1'b0, 5'd0, 64'h0, 2'b01, 5'd3, 5'd0);
    @(negedge clk);
    check_model();
    tick();
    check("lat1_valid_hit", 64'(rval2), 64'h1);
    check("lat1_data_hit", rdat2[0], 64'h55);
    set_in(1'b0, 5'd0, 64'h0, 2'b00, 5'd3, 5'd0);
    @(negedge clk);
    check_model();
    tick();
    check("lat1_valid_drop", 64'(rval2), 64'h0);
    check("lat1_data_hold", rdat2[0], 64'h55);

    // Asynchronous reset between edges while a write to X9 is pending.
    set_in(1'b1, 5'd9, 64'h99, 2'b11, 5'd9, 5'd9);
    @(negedge clk);
    check_model();
    tick();
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check("arst_cfg1_x9", rdat1[0], 64'h0);
    check("arst_cfg2_valid", 64'(rval2), 64'h0);
    check("arst_cfg2_data", rdat2[0] | rdat2[1], 64'h0);
    @(posedge clk);
    #1;
    check("arst_write_dropped", rdat1[1], 64'h0);
    reset_n = 1'b1;
    set_in(1'b0, 5'd0, 64'h0, 2'b11, 5'd9, 5'd9);
    @(negedge clk);
    check_model();
    tick();
    check("post_rst_x9", rdat0[0], 64'h0);
    check("post_rst_cfg2_valid", 64'(rval2), 64'h3);

    // Randomised traffic with biased address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      logic [4:0] ra [2];
      wa = 5'($urandom_range(0, 31));
      for (int p = 0; p < 2; p++)
        ra[p] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      set_in(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
             2'($urandom_range(0, 3)), ra[0], ra[1]);
      @(negedge clk);
      check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_multiport_bypass
